mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port external memory between the fetch stage (instruction reads) and the memory stage (load/store) of the pipeline. Serialises the two requesters with a fixed-priority FSM, drives a request/acknowledge handshake to the memory, and raises `freeze` so the pipeline holds while an access is outstanding. Sits between the fetch and memory stages and the memory port at the top level.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch read request; level, held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ready` is high.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `d_read`  in  1  load request; level, held until `d_ready`.
- `d_write`  in  1  store request; level, held until `d_ready`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; valid while `d_ready` is high.
- `d_ready`  out  1  one-cycle completion pulse for load/store.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req` is high.
- `mem_addr`  out  ADDR_W  latched address.
- `mem_wdata`  out  DATA_W  latched store data.
- `mem_rdata`  in  DATA_W  read data; sampled in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion from memory.
- `freeze`  out  1  pipeline hold.

## Operation
- States: IDLE, BUSY_D, BUSY_I, RESP.
- IDLE: if `d_read|d_write`, latch `d_addr`/`d_wdata`, set `mem_we=d_write`, go to BUSY_D. Else if `if_req`, latch `if_addr`, `mem_we=0`, go to BUSY_I. Else stay.
- Fixed priority: data over fetch, because the memory-stage instruction is older.
- `d_read` and `d_write` both high: treated as a write.
- BUSY_D / BUSY_I: `mem_req=1`. On `mem_ack`, register `mem_rdata` into the requester's rdata register, record the served requester, and go to RESP.
- RESP: pulse the served requester's `*_ready` for one cycle, then go to IDLE. No grant is issued in RESP, so a requester still holding its request during its ready cycle is never re-granted.
- Store completion: `d_ready` pulses; `d_rdata` keeps its previous value.
- `freeze` (combinational) = `((d_read|d_write) & ~d_ready) | (if_req & ~if_ready)`.
- `mem_ack` outside BUSY states: ignored.
- Requester drops its request mid-access: the access still completes to memory, and the ready pulse is still issued.
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_ready`, `d_ready` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; `freeze` follows its inputs.
- `rst` mid-access: IDLE on the next edge and `mem_req` drops. Any pending ack is then ignored.

## Timing
- Request seen in IDLE at cycle 0 → `mem_req` high in cycle 1.
- `mem_ack` in cycle k (k≥1) → `*_ready` and rdata valid in cycle k+1 → IDLE in cycle k+2.
- Minimum access: 3 cycles from request to the next grant opportunity.
- Both requesters pending: data is served first; fetch is granted in the IDLE cycle after data's RESP.
- `mem_addr`, `mem_we` and `mem_wdata` are registered and stable for the whole of `mem_req`.

## Configuration
- `MEM_ARB_IBUF_EN` defined: adds a single-entry fetch buffer holding a valid bit, an address and a data word.
  - Filled on every completed fetch.
  - Fetch in IDLE with `if_addr` equal to the buffered address and valid set (no data request pending): skip memory and go IDLE→RESP; `if_ready` in cycle 1 with the buffered data.
  - Any granted `d_write` clears the valid bit.
  - Reset clears the valid bit.
- Not defined: no buffer; every fetch goes to memory.

## Test plan
- Single fetch: `if_req=1`, `if_addr=0x10`; memory acks in cycle 3 with 0xE3A01005 → `mem_req` high in cycles 1–3, `if_ready` and `if_rdata=0xE3A01005` in cycle 4, `freeze` high in cycles 0–3.
- Simultaneous requests: `if_req` and `d_read` at 0x100 in the same cycle → data granted first (`mem_addr=0x100`, `mem_we=0`), `d_ready` pulses, then the fetch is granted in the following IDLE cycle.
- Store: `d_write=1`, `d_addr=0x200`, `d_wdata=0xDEADBEEF` → `mem_we=1`, `mem_wdata=0xDEADBEEF`; `d_ready` pulses one cycle after ack; `d_rdata` unchanged.
- Held request across the ready cycle: `d_read` kept high through RESP → exactly one memory access, then a new grant in IDLE.
- `rst` pulsed during BUSY_I → `mem_req=0` on the next edge; a late `mem_ack` is ignored and no `if_ready` is issued.
- With `MEM_ARB_IBUF_EN`:
  - Fetch 0x40 twice → the second fetch gets `if_ready` in cycle 1 with no `mem_req`.
  - After an intervening `d_write`, a third fetch of 0x40 goes to memory.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (data over fetch) arbiter in front of one single-port memory.
// Optional feature macro: MEM_ARB_IBUF_EN adds a single-entry fetch buffer for repeat fetches.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              freeze
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_e;

  state_e            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              d_req;
  logic              ibuf_hit;
  logic [DATA_W-1:0] ibuf_data;

  assign d_req = d_read | d_write;

`ifdef MEM_ARB_IBUF_EN
  logic              ibuf_valid_q;
  logic [ADDR_W-1:0] ibuf_addr_q;
  logic [DATA_W-1:0] ibuf_data_q;

  assign ibuf_hit  = if_req & ibuf_valid_q & (if_addr == ibuf_addr_q);
  assign ibuf_data = ibuf_data_q;

  // A write in IDLE is always granted (data wins), so it may have hit the buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_valid_q <= 1'b0;
    end else if (state_q == IDLE && d_write) begin
      ibuf_valid_q <= 1'b0;
    end else if (state_q == BUSY_I && mem_ack) begin
      ibuf_valid_q <= 1'b1;
    end
  end

  // NOTE: only the valid bit is reset; address/data are meaningless while it is clear.
  always_ff @(posedge clk) begin
    if (state_q == BUSY_I && mem_ack) begin
      ibuf_addr_q <= mem_addr_q;
      ibuf_data_q <= mem_rdata;
    end
  end
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_req) begin
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_we_q    <= d_write;
            mem_req_q   <= 1'b1;
            state_q     <= BUSY_D;
          end else if (ibuf_hit) begin
            if_rdata_q <= ibuf_data;
            if_ready_q <= 1'b1;
            state_q    <= RESP;
          end else if (if_req) begin
            mem_addr_q <= if_addr;
            mem_we_q   <= 1'b0;
            mem_req_q  <= 1'b1;
            state_q    <= BUSY_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            // Stores leave the load-data register untouched.
            if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
            d_ready_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            if_rdata_q <= mem_rdata;
            if_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign freeze    = (d_req & ~d_ready_q) | (if_req & ~if_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_IBUF_EN
  localparam bit IBUF_EN = 1'b1;
`else
  localparam bit IBUF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ready, d_ready, mem_req, mem_we, freeze;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: one outstanding access (owner/kind/address), plus which requester is due its ready pulse.
  bit            m_busy, m_owner_d, m_we, m_resp_if, m_resp_d, m_ibuf_v;
  logic [AW-1:0] m_addr, m_ibuf_a;
  logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata, m_ibuf_d;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_step();
    bit was_resp;
    if (rst) begin
      m_busy = 0; m_owner_d = 0; m_we = 0; m_resp_if = 0; m_resp_d = 0; m_ibuf_v = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
      return;
    end
    was_resp  = m_resp_if | m_resp_d;
    m_resp_if = 0;
    m_resp_d  = 0;
    if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (m_owner_d) begin
          m_resp_d = 1;
          if (!m_we) m_d_rdata = mem_rdata;
        end else begin
          m_resp_if  = 1;
          m_if_rdata = mem_rdata;
          m_ibuf_v   = 1;
          m_ibuf_a   = m_addr;
          m_ibuf_d   = mem_rdata;
        end
      end
    end else if (!was_resp) begin
      if (d_read | d_write) begin
        m_busy = 1; m_owner_d = 1; m_we = d_write; m_addr = d_addr; m_wdata = d_wdata;
        if (d_write) m_ibuf_v = 0;
      end else if (if_req) begin
        if (IBUF_EN && m_ibuf_v && if_addr == m_ibuf_a) begin
          m_resp_if  = 1;
          m_if_rdata = m_ibuf_d;
        end else begin
          m_busy = 1; m_owner_d = 0; m_we = 0; m_addr = if_addr;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mem_req", mem_req, m_busy);
      check("if_ready", if_ready, m_resp_if);
      check("d_ready", d_ready, m_resp_d);
      check("freeze", freeze, ((d_read | d_write) & ~m_resp_d) | (if_req & ~m_resp_if));
      if (m_busy) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, m_we);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_resp_if) check("if_rdata", if_rdata, m_if_rdata);
      if (m_resp_d) check("d_rdata", d_rdata, m_d_rdata);
    end
  end

  initial begin
    tick();
    cmp_en = 1'b1;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single fetch, ack in cycle 3.
    if_req = 1; if_addr = 32'h10;
    #1; check("s1_freeze_c0", freeze, 1); check("s1_mem_req_c0", mem_req, 0);
    tick();
    check("s1_mem_req_c1", mem_req, 1); check("s1_mem_addr_c1", mem_addr, 32'h10);
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'hE3A01005;
    #1; check("s1_mem_req_c3", mem_req, 1); check("s1_freeze_c3", freeze, 1);
    tick();
    mem_ack = 0; mem_rdata = '0;
    #1; check("s1_if_ready_c4", if_ready, 1); check("s1_if_rdata_c4", if_rdata, 32'hE3A01005);
    check("s1_freeze_c4", freeze, 0); check("s1_mem_req_c4", mem_req, 0);
    check("s1_model_pin", m_if_rdata, 32'hE3A01005);
    tick();
    if_req = 0;
    #1; check("s1_if_ready_c5", if_ready, 0);
    tick();
    check("s1_mem_req_c6", mem_req, 0);

    // Simultaneous fetch and load: data first.
    if_req = 1; if_addr = 32'h20; d_read = 1; d_addr = 32'h100;
    tick();
    check("s2_mem_addr", mem_addr, 32'h100); check("s2_mem_we", mem_we, 0);
    mem_ack = 1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 0;
    #1; check("s2_d_ready", d_ready, 1); check("s2_d_rdata", d_rdata, 32'h11112222);
    check("s2_if_ready", if_ready, 0); check("s2_freeze", freeze, 1);
    tick();
    d_read = 0;
    tick();
    check("s2_fetch_req", mem_req, 1); check("s2_fetch_addr", mem_addr, 32'h20);
    mem_ack = 1; mem_rdata = 32'h33334444;
    tick();
    mem_ack = 0;
    #1; check("s2_if_rdata", if_rdata, 32'h33334444);
    tick();
    if_req = 0;
    tick();

    // Store: load data register unchanged.
    d_write = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    tick();
    check("s3_mem_we", mem_we, 1); check("s3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("s3_mem_addr", mem_addr, 32'h200);
    tick();
    mem_ack = 1; mem_rdata = 32'h5555AAAA;
    tick();
    mem_ack = 0;
    #1; check("s3_d_ready", d_ready, 1); check("s3_d_rdata_kept", d_rdata, 32'h11112222);
    tick();
    d_write = 0;
    #1; check("s3_d_ready_off", d_ready, 0);
    tick();

    // Load held through its ready cycle, then dropped mid-access of the re-grant.
    d_read = 1; d_addr = 32'h300;
    tick();
    mem_ack = 1; mem_rdata = 32'h0A0B0C0D;
    tick();
    mem_ack = 0;
    #1; check("s4_d_ready", d_ready, 1); check("s4_mem_req_resp", mem_req, 0);
    tick();
    #1; check("s4_no_regrant_idle", mem_req, 0); check("s4_d_ready_idle", d_ready, 0);
    tick();
    check("s4_regrant", mem_req, 1); check("s4_regrant_addr", mem_addr, 32'h300);
    d_read = 0; mem_ack = 1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 0;
    #1; check("s4_drop_ready", d_ready, 1); check("s4_drop_rdata", d_rdata, 32'h12345678);
    tick();
    tick();

    // Stray ack while idle.
    mem_ack = 1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_ack = 0;
    #1; check("s5_mem_req", mem_req, 0); check("s5_if_ready", if_ready, 0);
    check("s5_d_ready", d_ready, 0);
    tick();

    // Reset during a fetch; the late ack must be ignored.
    if_req = 1; if_addr = 32'h44;
    tick();
    check("s6_mem_req_busy", mem_req, 1);
    rst = 1;
    tick();
    rst = 0; if_req = 0; mem_ack = 1; mem_rdata = 32'h77778888;
    #1; check("s6_mem_req_rst", mem_req, 0); check("s6_mem_addr_rst", mem_addr, 0);
    tick();
    mem_ack = 0;
    #1; check("s6_no_if_ready", if_ready, 0); check("s6_mem_req_after", mem_req, 0);
    tick();

    // Back-to-back fetches with ack latencies 1..4.
    for (int i = 0; i < 4; i++) begin
      if_req = 1; if_addr = 32'h1000 + 32'(i) * 4;
      tick();
      for (int k = 1; k < i + 1; k++) tick();
      mem_ack = 1; mem_rdata = $urandom;
      tick();
      mem_ack = 0;
      tick();
      if_req = 0;
      tick();
    end

`ifdef MEM_ARB_IBUF_EN
    // Fetch buffer: miss, hit, invalidate on store, miss again.
    if_req = 1; if_addr = 32'h40;
    tick();
    mem_ack = 1; mem_rdata = 32'hCAFE0040;
    tick();
    mem_ack = 0;
    #1; check("ib_fill_ready", if_ready, 1);
    tick();
    if_req = 0;
    tick();
    if_req = 1; if_addr = 32'h40;
    tick();
    check("ib_hit_ready", if_ready, 1); check("ib_hit_rdata", if_rdata, 32'hCAFE0040);
    check("ib_hit_no_req", mem_req, 0);
    tick();
    if_req = 0;
    tick();
    d_write = 1; d_addr = 32'h500; d_wdata = 32'h0BADF00D;
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    #1; check("ib_store_ready", d_ready, 1);
    tick();
    d_write = 0;
    tick();
    if_req = 1; if_addr = 32'h40;
    tick();
    check("ib_miss_req", mem_req, 1); check("ib_miss_addr", mem_addr, 32'h40);
    check("ib_miss_no_ready", if_ready, 0);
    mem_ack = 1; mem_rdata = 32'hCAFE0041;
    tick();
    mem_ack = 0;
    #1; check("ib_miss_rdata", if_rdata, 32'hCAFE0041);
    tick();
    if_req = 0;
    tick();
`endif

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
